// File: rtl/reg_bus_initiator_pkg.sv
// Shared constants for the register-port initiator: state codes, port widths and
// the default 32-entry boot table (colour/config values).
package reg_bus_initiator_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 8;
    localparam int unsigned REG_COUNT  = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_BOOT      = 2'd0;
    localparam state_t ST_IDLE      = 2'd1;
    localparam state_t ST_WRITE     = 2'd2;
    localparam state_t ST_READ_WAIT = 2'd3;

    localparam logic [REG_DATA_W-1:0] INIT_TABLE [REG_COUNT] = '{
        8'h00, 8'h1F, 8'h3C, 8'h07, 8'hE0, 8'hFC, 8'h1C, 8'h03,
        8'h92, 8'h49, 8'hB6, 8'h6D, 8'hFF, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'hA5, 8'h5A, 8'hC3,
        8'h3A, 8'h64, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h77, 8'h88
    };

endpackage

// File: rtl/reg_init_rom.sv
// Combinational lookup of the boot preload table, indexed by register address.
module reg_init_rom
    import reg_bus_initiator_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr_i,
    output logic [REG_DATA_W-1:0] data_o
);

    // Pure table read; the caller registers the result.
    always_comb begin
        data_o = INIT_TABLE[addr_i];
    end

endmodule

// File: rtl/reg_bus_initiator.sv
// Register-port initiator: turns host read/write commands into timed write/read strobes
// and returns read data on a one-cycle response pulse.
// Build option: REG_BUS_BOOT_INIT_EN adds a BOOT state that preloads registers
// 0..BOOT_COUNT-1 from the init table after reset.
module reg_bus_initiator
    import reg_bus_initiator_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BOOT_COUNT   = 32
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Cmd_Valid,
    output logic                  o_Cmd_Ready,
    input  logic                  i_Cmd_Write,
    input  logic [REG_ADDR_W-1:0] i_Cmd_Addr,
    input  logic [REG_DATA_W-1:0] i_Cmd_Data,
    output logic                  o_Rsp_Valid,
    output logic [REG_ADDR_W-1:0] o_Rsp_Addr,
    output logic [REG_DATA_W-1:0] o_Rsp_Data,
    output logic                  o_write_en,
    output logic [REG_ADDR_W-1:0] o_write_addr,
    output logic [REG_DATA_W-1:0] o_write_data,
    output logic                  o_read_en,
    output logic [REG_ADDR_W-1:0] o_read_addr,
    input  logic [REG_DATA_W-1:0] i_read_data,
    output logic                  o_Busy,
    output logic                  o_Boot_Done
);

    localparam logic [2:0] RD_LAT = 3'(READ_LATENCY);

`ifdef REG_BUS_BOOT_INIT_EN
    localparam state_t     ST_RESET = ST_BOOT;
    localparam logic [5:0] BOOT_CNT = 6'(BOOT_COUNT);
`else
    localparam state_t     ST_RESET = ST_IDLE;
    logic unused_boot_count;
    assign unused_boot_count = ^6'(BOOT_COUNT);
`endif

    state_t                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [REG_ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [REG_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  done_q, done_d;
    logic [2:0]            wait_q, wait_d;

`ifdef REG_BUS_BOOT_INIT_EN
    logic [5:0]            boot_k_q, boot_k_d;
    logic [REG_DATA_W-1:0] rom_data;

    reg_init_rom u_rom (
        .addr_i (boot_k_q[REG_ADDR_W-1:0]),
        .data_o (rom_data)
    );
`endif

    // Next-state and next-output decode; strobes and response default low each cycle.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        done_d      = done_q;
        wait_d      = wait_q;
`ifdef REG_BUS_BOOT_INIT_EN
        boot_k_d    = boot_k_q;
`endif
        case (state_q)
`ifdef REG_BUS_BOOT_INIT_EN
            ST_BOOT: begin
                if (boot_k_q < BOOT_CNT) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = boot_k_q[REG_ADDR_W-1:0];
                    wr_data_d = rom_data;
                    boot_k_d  = boot_k_q + 6'd1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
`ifndef REG_BUS_BOOT_INIT_EN
                done_d = 1'b1;
`endif
                if (i_Cmd_Valid) begin
                    if (i_Cmd_Write) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = i_Cmd_Addr;
                        wr_data_d = i_Cmd_Data;
                        state_d   = ST_WRITE;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = i_Cmd_Addr;
                        wait_d    = 3'd0;
                        state_d   = ST_READ_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ_WAIT: begin
                // wait_q counts edges since the strobe edge; data is valid once it hits RD_LAT.
                if (wait_q == RD_LAT) begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = rd_addr_q;
                    rsp_data_d  = i_read_data;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any pending command or boot sequence.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= ST_RESET;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            wait_q      <= 3'd0;
`ifdef REG_BUS_BOOT_INIT_EN
            boot_k_q    <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            wait_q      <= wait_d;
`ifdef REG_BUS_BOOT_INIT_EN
            boot_k_q    <= boot_k_d;
`endif
        end
    end

    assign o_Cmd_Ready  = (state_q == ST_IDLE);
    assign o_Busy       = (state_q != ST_IDLE);
    assign o_write_en   = wr_en_q;
    assign o_write_addr = wr_addr_q;
    assign o_write_data = wr_data_q;
    assign o_read_en    = rd_en_q;
    assign o_read_addr  = rd_addr_q;
    assign o_Rsp_Valid  = rsp_valid_q;
    assign o_Rsp_Addr   = rsp_addr_q;
    assign o_Rsp_Data   = rsp_data_q;
    assign o_Boot_Done  = done_q;

endmodule
